rvfi_commit_tracker: RTL
========================

Name: rvfi_commit_tracker

Overview:
- Multi-lane retirement monitor for the mp4 CPU. It generalises the single-lane commit/order/halt signalling to NRET commit lanes per cycle, which a superscalar or OoO core needs.
- Assigns a monotonically increasing order number to every committed instruction.
- Detects the self-loop halt idiom, flags malformed lane usage, watches for commit starvation, and keeps retire/cycle statistics.
- Sits between the core's retire stage and the RVFI monitor and shadow-memory hookup.

Parameters:
- NRET, 2, number of commit lanes per cycle (1..8).
- XLEN, 32, PC width.
- ORDER_W, 64, order counter width.
- CNT_W, 32, width of the statistics counters.
- HALT_REPEAT, 2, number of consecutive self-loop commits that declares halt (at least 1).
- TIMEOUT, 4096, number of consecutive zero-commit cycles that raises timeout; 0 disables it.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_commit  in  NRET  per-lane commit valid; lane 0 is the oldest.
- in_pc_rdata  in  NRET*XLEN  per-lane PC of the committed instruction; lane i is bits [i*XLEN +: XLEN].
- in_pc_wdata  in  NRET*XLEN  per-lane next PC.
- out_commit  out  NRET  registered copy of in_commit.
- out_order  out  NRET*ORDER_W  registered order number per lane; valid only where out_commit=1.
- halt  out  1  sticky, set when the halt condition is detected.
- lane_error  out  1  sticky, set on a non-contiguous commit mask.
- timeout  out  1  sticky, set on commit starvation.
- retire_count  out  CNT_W  total committed instructions, saturating.
- cycle_count  out  CNT_W  cycles since reset, saturating.

Behaviour:
- Reset (rst=0, asynchronous): all outputs go to 0. Internal base_order, loop_cnt and idle_cnt go to 0. Release is synchronous to the next clk edge.
- Latency: 1 cycle. Inputs sampled at edge t appear on out_commit/out_order after edge t.
- Order assignment:
  - order of lane i = base_order + popcount(in_commit[i-1:0]).
  - base_order += popcount(in_commit) each cycle.
  - Arithmetic is modulo 2^ORDER_W; wrap-around is silent.
  - Lanes with in_commit=0 present out_order=0.
- Lane contiguity:
  - A legal mask has the form 0..01..1, i.e. (mask & (mask+1)) == 0.
  - A violation sets lane_error on the next edge.
  - Orders are still assigned by prefix popcount, so holes do not consume order numbers.
- Halt detection:
  - Committed lanes are processed oldest to newest within a cycle.
  - A lane with pc_wdata == pc_rdata increments loop_cnt; loop_cnt saturates at HALT_REPEAT.
  - Any other committed lane clears loop_cnt to 0.
  - Non-committing lanes and zero-commit cycles leave loop_cnt unchanged.
  - halt is set on the edge where loop_cnt reaches HALT_REPEAT, including when that happens mid-cycle.
  - Once set, halt remains 1 until reset.
  - Commits after halt are still ordered and counted.
- Timeout:
  - idle_cnt increments on each cycle where in_commit == 0, saturating at TIMEOUT.
  - idle_cnt clears on any commit.
  - timeout is set when idle_cnt reaches TIMEOUT and is sticky.
  - idle_cnt is frozen while halt=1.
  - TIMEOUT=0 means timeout is never set.
- Statistics:
  - cycle_count increments every cycle after reset; retire_count increments by popcount(in_commit).
  - Both saturate at 2^CNT_W-1; retire_count clamps when the add would overflow.
- Simultaneous events: lane_error, halt and timeout can all set on the same edge; each is independent.
- Reset asserted mid-run: all state clears immediately, and the first post-reset commit receives order 0.

Decomposition:
- Package rvfi_mon_pkg:
  - default parameter constants;
  - popcount and prefix-popcount functions, parameterised by NRET;
  - a lane-contiguity check function.
- One sub-module, rvfi_halt_detector:
  - an NRET-lane sequential-scan chain that computes the next loop_cnt and a halt_hit pulse from commit/pc_rdata/pc_wdata;
  - the top holds the registers.

Test Plan:
- Reset, then NRET=2 with in_commit=2'b11 for 3 cycles (no self-loops):
  - out_order pairs are (0,1), (2,3), (4,5);
  - retire_count=6, halt=0.
- Mask 2'b01 then 2'b11:
  - orders 0, then (1,2);
  - an idle cycle in between leaves base_order unchanged.
- Mask 2'b10 with lane 1 pc=0x80 -> lane_error=1 one cycle later; lane 1 order=0; lane_error stays set.
- HALT_REPEAT=2:
  - lane0 pc 0x100->0x100 and lane1 pc 0x100->0x100 in one cycle -> halt=1 after that edge.
  - Separately: a self-loop, then pc 0x104->0x108, then one self-loop -> halt remains 0.
- TIMEOUT=8 with no commits for 8 cycles -> timeout=1 after the 8th edge.
- TIMEOUT=8 with a commit at idle cycle 7 -> timeout stays 0.
- Drive ORDER_W=4 to base_order 15 with mask 2'b11 -> orders (15,0), next base 1.
- Assert rst mid-run -> all outputs go to 0 asynchronously; the first commit after release gets order 0.

Source files
------------

// File: rtl/rvfi_mon_pkg.sv
// Shared constants and lane-mask helpers for the RVFI commit tracker.
// The helpers take the active lane count n so that one definition serves every NRET.
package rvfi_mon_pkg;

    localparam int unsigned NRET_MAX        = 8;
    localparam int unsigned PCNT_W          = 4;

    localparam int unsigned DEF_NRET        = 2;
    localparam int unsigned DEF_XLEN        = 32;
    localparam int unsigned DEF_ORDER_W     = 64;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_HALT_REPEAT = 2;
    localparam int unsigned DEF_TIMEOUT     = 4096;

    // Number of set bits among the lowest n lanes.
    function automatic logic [PCNT_W-1:0] popcount(input logic [NRET_MAX-1:0] mask,
                                                   input int unsigned n);
        logic [PCNT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NRET_MAX; i++) begin
            if (i < n && mask[i]) cnt = cnt + PCNT_W'(1);
        end
        return cnt;
    endfunction

    // Committed lanes strictly older than the given lane.
    function automatic logic [PCNT_W-1:0] prefix_popcount(input logic [NRET_MAX-1:0] mask,
                                                          input int unsigned lane);
        return popcount(mask, lane);
    endfunction

    // Legal masks are a run of ones starting at lane 0.
    function automatic logic lane_contiguous(input logic [NRET_MAX-1:0] mask);
        logic [NRET_MAX:0] m;
        m = {1'b0, mask};
        return (m & (m + (NRET_MAX+1)'(1))) == '0;
    endfunction

endpackage

// File: rtl/rvfi_halt_detector.sv
// Scans commit lanes oldest to newest, tracking consecutive self-loop commits.
// Produces the next loop count and a pulse when the count reaches HALT_REPEAT.
module rvfi_halt_detector #(
    parameter int unsigned NRET        = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HALT_REPEAT = 2,
    parameter int unsigned LOOP_W      = 2
) (
    input  logic [NRET-1:0]      commit,
    input  logic [NRET*XLEN-1:0] pc_rdata,
    input  logic [NRET*XLEN-1:0] pc_wdata,
    input  logic [LOOP_W-1:0]    loop_cnt,
    output logic [LOOP_W-1:0]    loop_cnt_next_c,
    output logic                 halt_hit_c
);

    logic [LOOP_W-1:0] cnt;
    logic              hit;

    always_comb begin
        cnt = loop_cnt;
        hit = 1'b0;
        for (int unsigned i = 0; i < NRET; i++) begin
            if (commit[i]) begin
                if (pc_wdata[i*XLEN +: XLEN] == pc_rdata[i*XLEN +: XLEN]) begin
                    if (cnt < LOOP_W'(HALT_REPEAT)) cnt = cnt + LOOP_W'(1);
                    if (cnt == LOOP_W'(HALT_REPEAT)) hit = 1'b1;
                end else begin
                    cnt = '0;
                end
            end
        end
        loop_cnt_next_c = cnt;
        halt_hit_c      = hit;
    end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Multi-lane retirement monitor: assigns order numbers, flags halt, malformed
// lane masks and commit starvation, and keeps saturating retire/cycle statistics.
module rvfi_commit_tracker
    import rvfi_mon_pkg::*;
#(
    parameter int unsigned NRET        = DEF_NRET,
    parameter int unsigned XLEN        = DEF_XLEN,
    parameter int unsigned ORDER_W     = DEF_ORDER_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRET-1:0]         in_commit,
    input  logic [NRET*XLEN-1:0]    in_pc_rdata,
    input  logic [NRET*XLEN-1:0]    in_pc_wdata,
    output logic [NRET-1:0]         out_commit,
    output logic [NRET*ORDER_W-1:0] out_order,
    output logic                    halt,
    output logic                    lane_error,
    output logic                    timeout,
    output logic [CNT_W-1:0]        retire_count,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam int unsigned LOOP_W = $clog2(HALT_REPEAT + 1);
    localparam int unsigned TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned SUM_W  = CNT_W + 1;

    logic [ORDER_W-1:0]      base_order;
    logic [LOOP_W-1:0]       loop_cnt;
    logic [TO_W-1:0]         idle_cnt;

    logic [NRET_MAX-1:0]     mask_ext_c;
    logic [PCNT_W-1:0]       pop_c;
    logic                    contig_c;
    logic [NRET*ORDER_W-1:0] order_c;
    logic [TO_W-1:0]         idle_next_c;
    logic [SUM_W-1:0]        retire_sum_c;
    logic [CNT_W-1:0]        retire_next_c;
    logic [LOOP_W-1:0]       loop_next_c;
    logic                    halt_hit_c;

    assign mask_ext_c    = NRET_MAX'(in_commit);
    assign pop_c         = popcount(mask_ext_c, NRET);
    assign contig_c      = lane_contiguous(mask_ext_c);
    assign retire_sum_c  = {1'b0, retire_count} + SUM_W'(pop_c);
    assign retire_next_c = retire_sum_c[CNT_W] ? '1 : retire_sum_c[CNT_W-1:0];

    rvfi_halt_detector #(
        .NRET        (NRET),
        .XLEN        (XLEN),
        .HALT_REPEAT (HALT_REPEAT),
        .LOOP_W      (LOOP_W)
    ) u_halt_detector (
        .commit          (in_commit),
        .pc_rdata        (in_pc_rdata),
        .pc_wdata        (in_pc_wdata),
        .loop_cnt        (loop_cnt),
        .loop_cnt_next_c (loop_next_c),
        .halt_hit_c      (halt_hit_c)
    );

    // Holes in the mask do not consume order numbers.
    always_comb begin
        order_c = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            if (in_commit[i]) begin
                order_c[i*ORDER_W +: ORDER_W] = base_order + ORDER_W'(prefix_popcount(mask_ext_c, i));
            end
        end
    end

    always_comb begin
        idle_next_c = '0;
        if (in_commit == '0) begin
            idle_next_c = (idle_cnt < TO_W'(TIMEOUT)) ? idle_cnt + TO_W'(1) : idle_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_commit   <= '0;
            out_order    <= '0;
            halt         <= 1'b0;
            lane_error   <= 1'b0;
            timeout      <= 1'b0;
            retire_count <= '0;
            cycle_count  <= '0;
            base_order   <= '0;
            loop_cnt     <= '0;
            idle_cnt     <= '0;
        end else begin
            out_commit   <= in_commit;
            out_order    <= order_c;
            base_order   <= base_order + ORDER_W'(pop_c);
            loop_cnt     <= loop_next_c;
            retire_count <= retire_next_c;
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
            if (halt_hit_c) halt <= 1'b1;
            if (!contig_c) lane_error <= 1'b1;
            // Starvation tracking stops once the core has halted.
            if (!halt) begin
                idle_cnt <= idle_next_c;
                if (TIMEOUT != 0 && idle_next_c == TO_W'(TIMEOUT)) timeout <= 1'b1;
            end
        end
    end

endmodule
